// File: rtl/register_bank.sv
// register_bank: REGS x N register file with two bypassed combinational read
// ports, one writeback port, and a per-entry pending-write scoreboard that
// lets decode stall instructions whose operands or destination are in flight.
module register_bank #(
  parameter  int N    = 24,
  parameter  int REGS = 16,
  localparam int A    = $clog2(REGS),
  localparam int C    = $clog2(REGS + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [A-1:0] ReadAddrA,
  input  logic [A-1:0] ReadAddrB,
  output logic [N-1:0] ReadDataA,
  output logic [N-1:0] ReadDataB,
  input  logic [A-1:0] WriteAddr,
  input  logic [N-1:0] WriteData,
  input  logic         WriteEn,
  input  logic [A-1:0] IssueAddr,
  input  logic         IssueEn,
  output logic         BusyA,
  output logic         BusyB,
  output logic         Stall,
  output logic [C-1:0] PendingCount
);

  logic [N-1:0]    r_mem [REGS];
  logic [REGS-1:0] r_busy;
  logic [C-1:0]    r_count;

  logic [REGS-1:0] w_effBusy;
  logic            w_writeHit;
  logic            w_issueAcc;
  logic            w_clearPend;

  // Entry 0 is the constant-zero register, so a write there is simply dropped.
  assign w_writeHit  = WriteEn && (WriteAddr != '0);
  assign w_clearPend = w_writeHit && r_busy[WriteAddr];
  assign w_issueAcc  = IssueEn && !Stall && (IssueAddr != '0);

  // Effective busy: a writeback landing this cycle already retires its entry.
  always_comb begin
    w_effBusy = r_busy;
    if (w_writeHit) begin
      w_effBusy[WriteAddr] = 1'b0;
    end
    w_effBusy[0] = 1'b0;
  end

  // Read port A: zero during reset and for entry 0, then bypass, then array.
  always_comb begin
    ReadDataA = '0;
    if (!rst && (ReadAddrA != '0)) begin
      if (w_writeHit && (WriteAddr == ReadAddrA)) begin
        ReadDataA = WriteData;
      end else begin
        ReadDataA = r_mem[ReadAddrA];
      end
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    ReadDataB = '0;
    if (!rst && (ReadAddrB != '0)) begin
      if (w_writeHit && (WriteAddr == ReadAddrB)) begin
        ReadDataB = WriteData;
      end else begin
        ReadDataB = r_mem[ReadAddrB];
      end
    end
  end

  // Hazard outputs are forced low while reset is held so nothing leaks through.
  always_comb begin
    BusyA = !rst && w_effBusy[ReadAddrA];
    BusyB = !rst && w_effBusy[ReadAddrB];
    Stall = !rst && IssueEn && (BusyA || BusyB || w_effBusy[IssueAddr]);
  end

  // Data array: writeback stores the word at the edge; entry 0 never changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_writeHit) begin
      r_mem[WriteAddr] <= WriteData;
    end
  end

  // Scoreboard bits: write clears first so a same-address accepted issue wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (w_writeHit) begin
        r_busy[WriteAddr] <= 1'b0;
      end
      if (w_issueAcc) begin
        r_busy[IssueAddr] <= 1'b1;
      end
    end
  end

  // Pending counter: +1 per accepted issue, -1 per write retiring a busy entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + C'(w_issueAcc) - C'(w_clearPend);
    end
  end

  assign PendingCount = r_count;

endmodule

// File: doc/register_bank.md
# register_bank

Multi-entry register bank with scoreboard for the processor's register stage. It holds REGS words of N bits, each behaving as an enable-gated register, and provides two combinational read ports with write-through bypass. It also tracks per-register "pending write" busy bits, so decode can stall an instruction whose sources or destination are still in flight. It sits between decode/issue (upstream) and writeback (which drives the write port).

## Interface
- N, 24, data width of every entry
- REGS, 16, number of entries (power of two, ≥ 2)
- A, $clog2(REGS), address width (derived, not overridden)
- C, $clog2(REGS+1), width of PendingCount (derived)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ReadAddrA  in  A  source A address
- ReadAddrB  in  A  source B address
- ReadDataA  out  N  source A data (combinational)
- ReadDataB  out  N  source B data (combinational)
- WriteAddr  in  A  writeback destination
- WriteData  in  N  writeback data
- WriteEn  in  1  writeback strobe
- IssueAddr  in  A  destination of the instruction being issued
- IssueEn  in  1  issue request
- BusyA  out  1  source A has a pending write
- BusyB  out  1  source B has a pending write
- Stall  out  1  issue request rejected this cycle
- PendingCount  out  C  number of busy entries

## Operation
- Entry 0 is hardwired to zero: reads return 0, writes are ignored, never busy, issue to 0 never sets busy.
- Write: when WriteEn=1 and WriteAddr≠0, the entry takes WriteData at the edge and busy[WriteAddr] clears.
- Read bypass: if WriteEn=1 and WriteAddr equals the read address (≠0), ReadData = WriteData in the same cycle; otherwise the stored value.
- Effective busy: busy[x] & ~(WriteEn & WriteAddr==x). BusyA and BusyB report the effective busy of their addresses.
- Stall = IssueEn & (BusyA | BusyB | effective busy[IssueAddr]). Stall is 0 whenever IssueEn=0.
- Issue accepted = IssueEn & ~Stall. On acceptance with IssueAddr≠0, busy[IssueAddr] sets at the edge.
- Simultaneous accepted issue and write to the same address: data is written and busy ends set (issue wins).
- PendingCount next = count + (accepted issue to a non-zero entry) − (write to a non-zero entry whose stored busy=1).
  - Same-address issue+write nets 0.
  - Count never exceeds REGS−1.
- A write to a non-busy entry updates data and leaves PendingCount unchanged.

## Timing
- Reset (async, asserted): all entries 0, all busy bits 0, PendingCount=0.
  - While rst=1: ReadDataA/B=0, BusyA/B=0, Stall=0, including any bypass path.
- Reset mid-operation clears immediately, without waiting for a clock edge. The first edge after deassertion behaves as normal operation.
- Read latency 0 cycles (combinational from addresses, plus bypass).
- Write latency 1 edge into the array; visible on the same cycle via bypass.
- Busy set latency 1 edge after accepted issue. Busy clear is visible the same cycle as the write (effective busy) and stored at the edge.
- Stall, BusyA and BusyB are combinational; no registered handshake. Upstream holds IssueEn/IssueAddr while Stall=1.
- PendingCount is registered and updates at the edge.

## Test plan
- Reset: drive writes, then pulse rst mid-cycle. Required: ReadDataA=0, PendingCount=0, Stall=0 immediately, with no edge needed.
- Write/bypass: WriteEn=1, WriteAddr=3, WriteData=24'h11111, ReadAddrA=3. Required: ReadDataA=24'h11111 in the same cycle and after the edge. With WriteEn=0 and ReadAddrB=3, required: 24'h11111.
- Entry 0: write 24'hAAAAA to addr 0, then issue to 0. Required: ReadData of 0 stays 0, Stall=0, PendingCount unchanged.
- Scoreboard:
  - Issue to 5: PendingCount 0→1.
  - Next cycle, IssueEn with ReadAddrA=5. Required: BusyA=1, Stall=1, count stays 1.
  - Write 24'h44444 to 5. Required: BusyA=0 and Stall=0 that cycle; count→0 (1 if the issue is accepted).
- Same-address: busy[7]=1; issue to 7 with write 24'h77777 to 7 in the same cycle. Required: Stall=0, entry 7=24'h77777, busy[7]=1, PendingCount unchanged.
- Fill: issue to 1..15 on consecutive cycles with no writes. Required: PendingCount=15, then a 16th issue to 3 gives Stall=1.
